func_decoder: RTL and testbench



---
 rtl/func_decoder.sv | 51 +++++
 tb/tb_func_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/func_decoder.sv
// rtl/func_decoder.sv - registered 3-to-8 one-hot decoder with minterm-mask function outputs
module func_decoder #(
    parameter logic [7:0] F1_MINTERMS = 8'b1001_0110,
    parameter logic [7:0] F2_MINTERMS = 8'b1110_1000,
    parameter logic [7:0] F3_MINTERMS = 8'b0101_0101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] inp,
    output logic [7:0] dec,
    output logic       f1,
    output logic       f2,
    output logic       f3,
    output logic       valid
);

    logic [7:0] d;
    logic       f1_next;
    logic       f2_next;
    logic       f3_next;

    always_comb begin
        d      = 8'h00;
        d[inp] = 1'b1;
    end

    // Each function is the sum of the minterms its mask selects.
    assign f1_next = |(d & F1_MINTERMS);
    assign f2_next = |(d & F2_MINTERMS);
    assign f3_next = |(d & F3_MINTERMS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec   <= 8'h00;
            f1    <= 1'b0;
            f2    <= 1'b0;
            f3    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                dec <= d;
                f1  <= f1_next;
                f2  <= f2_next;
                f3  <= f3_next;
            end
        end
    end

endmodule

// File: tb/tb_func_decoder.sv
// tb/tb_func_decoder.sv - self-checking bench for func_decoder (default and overridden masks)
module tb_func_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] inp;
    logic [7:0] dec, dec_m;
    logic       f1, f2, f3, valid;
    logic       f1_m, f2_m, f3_m, valid_m;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: last sampled value, whether anything was sampled, last en
    logic [2:0] mlast;
    logic       mhave;
    logic       mvalid;

    typedef struct {
        logic       en;
        logic [2:0] inp;
        logic [7:0] dec;
        logic       f1;
        logic       f2;
        logic       f3;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    func_decoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inp   (inp),
        .dec   (dec),
        .f1    (f1),
        .f2    (f2),
        .f3    (f3),
        .valid (valid)
    );

    func_decoder #(
        .F1_MINTERMS (8'h00),
        .F2_MINTERMS (8'hFF),
        .F3_MINTERMS (8'h80)
    ) u_mask (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inp   (inp),
        .dec   (dec_m),
        .f1    (f1_m),
        .f2    (f2_m),
        .f3    (f3_m),
        .valid (valid_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            mvalid = en;
            if (en) begin
                mlast = inp;
                mhave = 1'b1;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        mhave  = 1'b0;
        mvalid = 1'b0;
        mlast  = 3'd0;
    endtask

    task automatic chk(input string name,
                       input logic [7:0] gd, input logic g1, input logic g2, input logic g3, input logic gv,
                       input logic [7:0] ed, input logic e1, input logic e2, input logic e3, input logic ev);
        vectors++;
        if (gd !== ed || g1 !== e1 || g2 !== e2 || g3 !== e3 || gv !== ev) begin
            miscompares++;
            $display("FAIL %s: got dec=%h f1=%b f2=%b f3=%b valid=%b, expected dec=%h f1=%b f2=%b f3=%b valid=%b",
                     name, gd, g1, g2, g3, gv, ed, e1, e2, e3, ev);
        end
    endtask

    // Full adder on A,B,C plus "C is zero", computed arithmetically.
    task automatic chk_model(input string name);
        int         s;
        logic [7:0] ed;
        s  = int'(mlast[2]) + int'(mlast[1]) + int'(mlast[0]);
        ed = mhave ? (8'd1 << mlast) : 8'h00;
        chk(name, dec, f1, f2, f3, valid,
            ed, mhave && (s % 2 == 1), mhave && (s >= 2), mhave && (mlast[0] == 1'b0), mvalid);
        chk({name, "_mask"}, dec_m, f1_m, f2_m, f3_m, valid_m,
            ed, 1'b0, mhave, mhave && (mlast == 3'd7), mvalid);
    endtask

    function automatic vec_t mk(logic e, logic [2:0] i, logic [7:0] d,
                                logic a, logic b, logic c, logic v);
        vec_t r;
        r.en = e; r.inp = i; r.dec = d; r.f1 = a; r.f2 = b; r.f3 = c; r.valid = v;
        return r;
    endfunction

    initial begin
        logic [7:0] f1_exp, f2_exp, f3_exp;
        f1_exp = 8'b1001_0110;
        f2_exp = 8'b1110_1000;
        f3_exp = 8'b0101_0101;

        // sweep 0..7 with the listed per-value responses
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b1, 3'(k), 8'd1 << k, f1_exp[k], f2_exp[k], f3_exp[k], 1'b1));
        // hold
        vecs.push_back(mk(1'b1, 3'd3, 8'h08, 1'b0, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b0, 3'd4, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0));
        // en toggling
        vecs.push_back(mk(1'b1, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 3'd6, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd6, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0));

        // reset held, independent of clk
        rst_n = 1'b0;
        en    = 1'b1;
        inp   = 3'b111;
        model_reset();
        #1;
        chk("reset_pre_clk", dec, f1, f2, f3, valid, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_model("reset_held");
        end
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            en  = vecs[k].en;
            inp = vecs[k].inp;
            step();
            chk($sformatf("table_%0d", k), dec, f1, f2, f3, valid,
                vecs[k].dec, vecs[k].f1, vecs[k].f2, vecs[k].f3, vecs[k].valid);
            chk_model($sformatf("table_model_%0d", k));
        end

        // async reset between edges, then first sample after release
        en  = 1'b1;
        inp = 3'b111;
        step();
        chk("pre_async", dec, f1, f2, f3, valid, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset", dec, f1, f2, f3, valid, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_model("async_reset_model");
        rst_n = 1'b1;
        inp   = 3'b001;
        step();
        chk("after_release", dec, f1, f2, f3, valid, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);

        // slow stimulus: change only takes effect at the next edge, then stays stable
        en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] prev;
            prev = mlast;
            inp = 3'(v);
            #1;
            if (v > 0) begin
                vectors++;
                if (dec !== (8'd1 << prev)) begin
                    miscompares++;
                    $display("FAIL slow_early_%0d: got dec=%h, expected dec=%h", v, dec, 8'd1 << prev);
                end
            end
            for (int c = 0; c < 10; c++) begin
                step();
                chk_model($sformatf("slow_%0d_%0d", v, c));
            end
        end

        // randomized stimulus with occasional asynchronous reset pulses
        for (int n = 0; n < 400; n++) begin
            en  = 1'($urandom_range(0, 1));
            inp = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                model_reset();
                #1;
                chk_model("rand_reset");
                rst_n = 1'b1;
            end
            step();
            chk_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
